// File: rtl/audio_pkg.sv
// Shared types and default parameter values for the PWM audio serializer.
package audio_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_e;

   localparam int DEF_WIDTH     = 16;
   localparam int DEF_MSB_FIRST = 0;
   localparam int DEF_BIT_DIV   = 1;
   localparam int DEF_WINDOW    = 100;
   localparam int DEF_THRESHOLD = 56;

endpackage

// File: rtl/loudness_meter.sv
// Counts high cycles of the serial audio bit over fixed windows and flags
// the window as loud when the count reaches THRESHOLD.
module loudness_meter
   import audio_pkg::*;
#(
   parameter int WINDOW    = DEF_WINDOW,
   parameter int THRESHOLD = DEF_THRESHOLD
) (
   input  logic clock_i,
   input  logic reset_i,
   input  logic enable_i,
   input  logic bit_i,
   output logic voice_indicator_o
);

   localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW - 1);

   if (WINDOW < 1 || THRESHOLD < 0 || THRESHOLD > WINDOW) begin : g_bad_params
      $fatal(1, "loudness_meter: illegal WINDOW/THRESHOLD");
   end

   logic [CW-1:0] win_cnt_q, win_cnt_d;
   logic [CW-1:0] high_cnt_q, high_cnt_d;
   logic          voice_q, voice_d;
   logic [CW:0]   high_total;

   always_comb begin
      win_cnt_d  = win_cnt_q;
      high_cnt_d = high_cnt_q;
      voice_d    = voice_q;
      // The terminal cycle's own bit is part of its window.
      high_total = {1'b0, high_cnt_q} + {{CW{1'b0}}, bit_i};
      if (!enable_i) begin
         win_cnt_d  = '0;
         high_cnt_d = '0;
         voice_d    = 1'b0;
      end else if (win_cnt_q == WIN_LAST) begin
         voice_d    = (int'(high_total) >= THRESHOLD);
         win_cnt_d  = '0;
         high_cnt_d = '0;
      end else begin
         win_cnt_d  = win_cnt_q + CW'(1);
         high_cnt_d = high_cnt_q + {{(CW-1){1'b0}}, bit_i};
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         win_cnt_q  <= '0;
         high_cnt_q <= '0;
         voice_q    <= 1'b0;
      end else begin
         win_cnt_q  <= win_cnt_d;
         high_cnt_q <= high_cnt_d;
         voice_q    <= voice_d;
      end
   end

   assign voice_indicator_o = voice_q;

endmodule

// File: rtl/pwm_serializer.sv
// Serializes audio sample words onto a single registered PWM bit, with a
// one-word holding register for gapless playback and a loudness flag.
module pwm_serializer
   import audio_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int MSB_FIRST = DEF_MSB_FIRST,
   parameter int BIT_DIV   = DEF_BIT_DIV,
   parameter int WINDOW    = DEF_WINDOW,
   parameter int THRESHOLD = DEF_THRESHOLD
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             enable_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic             done_o,
   output logic             underrun_o,
   output logic             pwm_audio_o,
   output logic             pwm_sdaudio_o,
   output logic             voice_indicator_o
);

   localparam int BW = $clog2(WIDTH);
   localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);

   if (WIDTH < 2 || BIT_DIV < 1 || (MSB_FIRST != 0 && MSB_FIRST != 1)) begin : g_bad_params
      $fatal(1, "pwm_serializer: illegal WIDTH/BIT_DIV/MSB_FIRST");
   end

   ser_state_e       state_q, state_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [DW-1:0]    div_cnt_q, div_cnt_d;
   logic             pwm_q, pwm_d;
   logic             sd_q, sd_d;
   logic             load, accept, bit_last, word_last, done_c, underrun_c;
   logic [WIDTH-1:0] shift_next;

   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
   endfunction

   // valid/ready: a word moves into the holding register on any edge where
   // valid_i && ready_o; ready_o is low exactly while the register is full,
   // so a write and a load into the shift register never share an edge.
   assign ready_o = !hold_full_q;
   assign accept  = valid_i && !hold_full_q;

   assign bit_last   = (div_cnt_q == DIV_LAST);
   assign word_last  = bit_last && (bit_cnt_q == BIT_LAST);
   assign shift_next = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      div_cnt_d   = div_cnt_q;
      pwm_d       = pwm_q;
      sd_d        = 1'b1;
      load        = 1'b0;
      done_c      = 1'b0;
      underrun_c  = 1'b0;
      if (!enable_i) begin
         state_d   = IDLE;
         pwm_d     = 1'b0;
         bit_cnt_d = '0;
         div_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               pwm_d = 1'b0;
               load  = hold_full_q;
            end
            SHIFT: begin
               if (!bit_last) begin
                  div_cnt_d = div_cnt_q + DW'(1);
               end else if (!word_last) begin
                  div_cnt_d = '0;
                  bit_cnt_d = bit_cnt_q + BW'(1);
                  shift_d   = shift_next;
                  pwm_d     = first_bit(shift_next);
               end else begin
                  done_c = 1'b1;
                  if (hold_full_q) begin
                     load = 1'b1;
                  end else begin
                     underrun_c = 1'b1;
                     pwm_d      = 1'b0;
                     state_d    = IDLE;
                     bit_cnt_d  = '0;
                     div_cnt_d  = '0;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
      if (load) begin
         state_d     = SHIFT;
         shift_d     = hold_q;
         pwm_d       = first_bit(hold_q);
         bit_cnt_d   = '0;
         div_cnt_d   = '0;
         hold_full_d = 1'b0;
      end
      if (accept) begin
         hold_d      = data_i;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         div_cnt_q   <= '0;
         pwm_q       <= 1'b0;
         sd_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         div_cnt_q   <= div_cnt_d;
         pwm_q       <= pwm_d;
         sd_q        <= sd_d;
      end
   end

   assign done_o        = done_c && !reset_i;
   assign underrun_o    = underrun_c && !reset_i;
   assign pwm_audio_o   = pwm_q;
   assign pwm_sdaudio_o = sd_q;

   loudness_meter #(
      .WINDOW   (WINDOW),
      .THRESHOLD(THRESHOLD)
   ) u_loudness (
      .clock_i          (clock_i),
      .reset_i          (reset_i),
      .enable_i         (enable_i),
      .bit_i            (pwm_q),
      .voice_indicator_o(voice_indicator_o)
   );

endmodule

// File: tb/tb_pwm_serializer.sv
// Bench for pwm_serializer: two instances (LSB-first/div 1 and MSB-first/div 4)
// checked every cycle against a word/position-level reference model.
module tb_pwm_serializer;

   localparam int W    = 16;
   localparam int WIN  = 100;
   localparam int THR  = 56;
   localparam int DIV0 = 1;
   localparam int DIV1 = 4;

   logic         clock_i  = 1'b0;
   logic         reset_i  = 1'b1;
   logic         enable_i = 1'b0;
   logic         valid_i  = 1'b0;
   logic [W-1:0] data_i   = '0;

   logic [1:0] ready_v, done_v, under_v, pwm_v, sd_v, voice_v;

   pwm_serializer #(.WIDTH(W), .MSB_FIRST(0), .BIT_DIV(DIV0), .WINDOW(WIN), .THRESHOLD(THR)) u_dut0 (
      .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .data_i(data_i),
      .valid_i(valid_i), .ready_o(ready_v[0]), .done_o(done_v[0]), .underrun_o(under_v[0]),
      .pwm_audio_o(pwm_v[0]), .pwm_sdaudio_o(sd_v[0]), .voice_indicator_o(voice_v[0])
   );

   pwm_serializer #(.WIDTH(W), .MSB_FIRST(1), .BIT_DIV(DIV1), .WINDOW(WIN), .THRESHOLD(THR)) u_dut1 (
      .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .data_i(data_i),
      .valid_i(valid_i), .ready_o(ready_v[1]), .done_o(done_v[1]), .underrun_o(under_v[1]),
      .pwm_audio_o(pwm_v[1]), .pwm_sdaudio_o(sd_v[1]), .voice_indicator_o(voice_v[1])
   );

   // ---------------- clock ----------------
   always #5 clock_i = ~clock_i;

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int           m_div [2] = '{DIV0, DIV1};
   int           m_msb [2] = '{0, 1};
   bit           m_play [2];
   bit           m_held [2];
   logic [W-1:0] m_word [2];
   logic [W-1:0] m_hword [2];
   int           m_pos [2];
   int           m_win [2];
   int           m_high [2];
   bit           m_voice [2];
   bit           m_sd [2];
   bit           m_ok = 1'b0;

   function automatic bit bit_at(input int k, input logic [W-1:0] w, input int pos);
      int idx;
      idx = pos / m_div[k];
      if (m_msb[k] != 0) return w[W-1-idx];
      return w[idx];
   endfunction

   // Samples one time unit before each rising edge, then advances the model
   // through that edge using the inputs the DUTs are about to see.
   always @(negedge clock_i) begin
      int len;
      bit e_pwm, e_done, e_under, acc;
      #4;
      for (int k = 0; k < 2; k++) begin
         len     = W * m_div[k];
         e_pwm   = m_play[k] ? bit_at(k, m_word[k], m_pos[k]) : 1'b0;
         e_done  = !reset_i && enable_i && m_play[k] && (m_pos[k] == len - 1);
         e_under = e_done && !m_held[k];
         if (m_ok) begin
            check($sformatf("d%0d_ready", k), ready_v[k], !m_held[k]);
            check($sformatf("d%0d_pwm", k),   pwm_v[k],   e_pwm);
            check($sformatf("d%0d_done", k),  done_v[k],  e_done);
            check($sformatf("d%0d_under", k), under_v[k], e_under);
            check($sformatf("d%0d_voice", k), voice_v[k], m_voice[k]);
            check($sformatf("d%0d_sd", k),    sd_v[k],    m_sd[k]);
         end
         if (reset_i) begin
            m_play[k] = 0; m_held[k] = 0; m_pos[k] = 0;
            m_win[k] = 0; m_high[k] = 0; m_voice[k] = 0; m_sd[k] = 0;
         end else begin
            m_sd[k] = 1;
            acc = valid_i && !m_held[k];
            if (!enable_i) begin
               m_play[k] = 0;
            end else if (m_play[k]) begin
               if (m_pos[k] == len - 1) begin
                  if (m_held[k]) begin
                     m_word[k] = m_hword[k]; m_pos[k] = 0; m_held[k] = 0;
                  end else begin
                     m_play[k] = 0;
                  end
               end else begin
                  m_pos[k]++;
               end
            end else if (m_held[k]) begin
               m_play[k] = 1; m_word[k] = m_hword[k]; m_pos[k] = 0; m_held[k] = 0;
            end
            if (acc) begin
               m_held[k] = 1; m_hword[k] = data_i;
            end
            if (enable_i) begin
               m_win[k]++;
               m_high[k] += e_pwm;
               if (m_win[k] == WIN) begin
                  m_voice[k] = (m_high[k] >= THR);
                  m_win[k] = 0; m_high[k] = 0;
               end
            end else begin
               m_win[k] = 0; m_high[k] = 0; m_voice[k] = 0;
            end
         end
      end
      if (reset_i) m_ok = 1'b1;
   end

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(negedge clock_i);
   endtask

   task automatic do_reset();
      reset_i = 1; enable_i = 0; valid_i = 0;
      cyc(); cyc();
      check("rst_ready", ready_v[0], 1);
      check("rst_pwm",   pwm_v[0],   0);
      check("rst_sd",    sd_v[0],    0);
      check("rst_voice", voice_v[0], 0);
      check("rst_done",  done_v[0],  0);
      reset_i = 0;
      cyc();
      check("sd_on", sd_v[0], 1);
   endtask

   function automatic logic [W-1:0] make_word(input int wi, input int highs);
      logic [W-1:0] w;
      int t;
      for (int b = 0; b < W; b++) begin
         t    = wi * W + b;
         w[b] = (((t + 2) % WIN) >= (WIN - highs));
      end
      return w;
   endfunction

   logic [2:0]  exp_q[$];
   logic [2:0]  e;
   logic [15:0] seq;
   int nd, nu, wi, hk;
   bit heavy;

   initial begin
      // A5C3, LSB first, single word then underrun
      do_reset();
      seq = 16'b1100_0011_1010_0101;
      for (int i = 0; i < 16; i++) exp_q.push_back({seq[15-i], (i == 15), (i == 15)});
      enable_i = 1; data_i = 16'hA5C3; valid_i = 1;
      cyc();
      valid_i = 0;
      cyc();
      for (int i = 0; i < 16; i++) begin
         e = exp_q.pop_front();
         check("a5c3_pwm",   pwm_v[0],   e[2]);
         check("a5c3_done",  done_v[0],  e[1]);
         check("a5c3_under", under_v[0], e[0]);
         cyc();
      end
      check("a5c3_idle_pwm", pwm_v[0], 0);
      check("a5c3_ready",    ready_v[0], 1);

      // FFFF then 0000 refilled during the first word: gapless 32 bits
      do_reset();
      enable_i = 1; data_i = 16'hFFFF; valid_i = 1;
      cyc();
      valid_i = 0;
      cyc();
      nd = 0; nu = 0;
      for (int i = 0; i < 34; i++) begin
         check("ff00_pwm",   pwm_v[0],   (i < 16) ? 1 : 0);
         check("ff00_done",  done_v[0],  (i == 15 || i == 31) ? 1 : 0);
         check("ff00_under", under_v[0], (i == 31) ? 1 : 0);
         nd += done_v[0];
         nu += under_v[0];
         if (i == 0) begin
            check("ff00_ready", ready_v[0], 1);
            data_i = 16'h0000; valid_i = 1;
         end else begin
            valid_i = 0;
         end
         cyc();
      end
      check("ff00_ndone",  nd, 2);
      check("ff00_nunder", nu, 1);

      // MSB first, 4 cycles per bit on the second instance
      do_reset();
      enable_i = 1; data_i = 16'h8001; valid_i = 1;
      cyc();
      valid_i = 0;
      cyc();
      for (int i = 0; i < 65; i++) begin
         check("msb_pwm",  pwm_v[1],  (i < 4 || (i >= 60 && i < 64)) ? 1 : 0);
         check("msb_done", done_v[1], (i == 63) ? 1 : 0);
         cyc();
      end

      // Loudness with continuous full-scale and silent streams
      do_reset();
      enable_i = 1; data_i = 16'hFFFF; valid_i = 1;
      repeat (120) cyc();
      check("loud_ff_voice0", voice_v[0], 1);
      check("loud_ff_voice1", voice_v[1], 1);
      data_i = 16'h0000;
      repeat (250) cyc();
      check("loud_00_voice0", voice_v[0], 0);
      data_i = 16'hFFFF;
      repeat (250) cyc();
      check("loud_ff2_voice0", voice_v[0], 1);
      enable_i = 0;
      cyc();
      check("dis_voice0", voice_v[0], 0);
      check("dis_voice1", voice_v[1], 0);
      check("dis_pwm0",   pwm_v[0],   0);
      check("dis_ready0", ready_v[0], 0);
      valid_i = 0;
      cyc();

      // Reset at bit 7 with a word held
      do_reset();
      enable_i = 1; data_i = 16'h5555; valid_i = 1;
      cyc();
      data_i = 16'h1234;
      cyc();
      cyc();
      valid_i = 0;
      repeat (6) cyc();
      check("mid_ready_held", ready_v[0], 0);
      reset_i = 1;
      cyc();
      check("mid_rst_pwm",   pwm_v[0],   0);
      check("mid_rst_done",  done_v[0],  0);
      check("mid_rst_under", under_v[0], 0);
      check("mid_rst_voice", voice_v[0], 0);
      check("mid_rst_sd",    sd_v[0],    0);
      check("mid_rst_ready", ready_v[0], 1);
      reset_i = 0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("post_rst_silent", pwm_v[0], 0);
      end
      data_i = 16'h0001; valid_i = 1;
      cyc();
      valid_i = 0;
      cyc();
      check("post_rst_bit0", pwm_v[0], 1);
      cyc();
      check("post_rst_bit1", pwm_v[0], 0);

      // Exactly 56 vs 55 high cycles per window
      for (int kk = 0; kk < 2; kk++) begin
         hk = (kk == 0) ? 56 : 55;
         do_reset();
         enable_i = 1; wi = 0;
         for (int c = 0; c < 330; c++) begin
            if (ready_v[0]) begin
               data_i = make_word(wi, hk);
               wi++;
               valid_i = 1;
            end
            if (c == 150) check($sformatf("thr%0d_mid_voice", hk), voice_v[0], (hk >= THR) ? 1 : 0);
            cyc();
         end
         check($sformatf("thr%0d_end_voice", hk), voice_v[0], (hk >= THR) ? 1 : 0);
      end

      // Random traffic, enable drops and occasional resets
      do_reset();
      heavy = 1;
      for (int c = 0; c < 3000; c++) begin
         if (c % 400 == 0) heavy = ~heavy;
         enable_i = ($urandom_range(0, 99) < 95);
         valid_i  = ($urandom_range(0, 3) != 0);
         data_i   = heavy ? W'($urandom | $urandom) : W'($urandom & $urandom);
         reset_i  = ($urandom_range(0, 499) == 0);
         cyc();
      end
      reset_i = 0; valid_i = 0; enable_i = 0;
      cyc(); cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
